// File: rtl/id_ex_stage.sv
// ID/EX pipeline boundary: registers decoded operands/control into EX and owns the stage interlock.
// Optional performance counters are present when ID_EX_PERF_CNT_EN is defined.
module id_ex_stage #(
   parameter int DATA_WIDTH = 64,
   parameter int CTRL_WIDTH = 16,
   parameter int MULTI_LAT  = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  id_valid,
   input  logic [4:0]            id_rA_address,
   input  logic [4:0]            id_rB_address,
   input  logic [4:0]            id_rD_address,
   input  logic                  id_use_rA,
   input  logic                  id_use_rB,
   input  logic [DATA_WIDTH-1:0] id_rA_data,
   input  logic [DATA_WIDTH-1:0] id_rB_data,
   input  logic [CTRL_WIDTH-1:0] id_ctrl,
   input  logic                  id_is_load,
   input  logic                  id_is_multi,
   input  logic                  flush,
   input  logic                  mem_stall,
   output logic                  ex_valid,
   output logic [4:0]            ex_rA_address,
   output logic [4:0]            ex_rB_address,
   output logic [4:0]            ex_rD_address,
   output logic [DATA_WIDTH-1:0] ex_rA_data,
   output logic [DATA_WIDTH-1:0] ex_rB_data,
   output logic [CTRL_WIDTH-1:0] ex_ctrl,
   output logic                  ex_is_load,
   output logic                  ex_is_multi,
   output logic                  stall_id,
`ifdef ID_EX_PERF_CNT_EN
   output logic [31:0]           stall_cycles,
   output logic [31:0]           bubble_count,
`endif
   output logic                  ex_busy
);

   typedef enum logic [0:0] {RUN = 1'b0, MULTI = 1'b1} state_t;

   localparam logic       MULTI_EN  = (MULTI_LAT > 1);
   localparam logic [3:0] HOLD_INIT = 4'(MULTI_LAT - 1);

   state_t                state_r;
   state_t                state_nxt_s;
   logic [3:0]            cnt_r;
   logic [3:0]            cnt_nxt_s;
   logic                  busy_r;
   logic                  hazard_s;
   logic                  stall_s;
   logic                  update_s;
   logic                  take_s;
   logic                  bubble_evt_s;

   logic                  ex_valid_r;
   logic [4:0]            ex_rA_address_r;
   logic [4:0]            ex_rB_address_r;
   logic [4:0]            ex_rD_address_r;
   logic [DATA_WIDTH-1:0] ex_rA_data_r;
   logic [DATA_WIDTH-1:0] ex_rB_data_r;
   logic [CTRL_WIDTH-1:0] ex_ctrl_r;
   logic                  ex_is_load_r;
   logic                  ex_is_multi_r;

   // Load-use hazard: ID reads the register the load in EX is about to write (r0 included).
   always_comb begin
      hazard_s = ex_valid_r & ex_is_load_r & id_valid &
                 ((id_use_rA & (id_rA_address == ex_rD_address_r)) |
                  (id_use_rB & (id_rB_address == ex_rD_address_r)));
   end

   // Interlock next-state logic: mem_stall > multi-cycle hold > flush > load-use > capture.
   always_comb begin
      state_nxt_s  = state_r;
      cnt_nxt_s    = cnt_r;
      stall_s      = 1'b0;
      update_s     = 1'b0;
      take_s       = 1'b0;
      bubble_evt_s = 1'b0;
      if (mem_stall) begin
         stall_s = 1'b1;
      end else begin
         case (state_r)
            MULTI: begin
               stall_s = 1'b1;
               if (cnt_r > 4'd1) begin
                  cnt_nxt_s = cnt_r - 4'd1;
               end else begin
                  cnt_nxt_s   = 4'd0;
                  state_nxt_s = RUN;
               end
            end
            RUN: begin
               update_s = 1'b1;
               if (flush) begin
                  bubble_evt_s = 1'b1;
               end else if (hazard_s) begin
                  bubble_evt_s = 1'b1;
                  stall_s      = 1'b1;
               end else begin
                  take_s = id_valid;
                  if (id_valid & id_is_multi & MULTI_EN) begin
                     state_nxt_s = MULTI;
                     cnt_nxt_s   = HOLD_INIT;
                  end else begin
                     cnt_nxt_s = 4'd0;
                  end
               end
            end
            default: begin
               state_nxt_s = RUN;
               cnt_nxt_s   = 4'd0;
            end
         endcase
      end
   end

   // State, hold counter and EX pipeline registers; a non-taken update loads a bubble.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r         <= RUN;
         cnt_r           <= 4'd0;
         busy_r          <= 1'b0;
         ex_valid_r      <= 1'b0;
         ex_rA_address_r <= 5'd0;
         ex_rB_address_r <= 5'd0;
         ex_rD_address_r <= 5'd0;
         ex_rA_data_r    <= {DATA_WIDTH{1'b0}};
         ex_rB_data_r    <= {DATA_WIDTH{1'b0}};
         ex_ctrl_r       <= {CTRL_WIDTH{1'b0}};
         ex_is_load_r    <= 1'b0;
         ex_is_multi_r   <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
         busy_r  <= (state_nxt_s == MULTI);
         if (update_s) begin
            if (take_s) begin
               ex_valid_r      <= 1'b1;
               ex_rA_address_r <= id_rA_address;
               ex_rB_address_r <= id_rB_address;
               ex_rD_address_r <= id_rD_address;
               ex_rA_data_r    <= id_rA_data;
               ex_rB_data_r    <= id_rB_data;
               ex_ctrl_r       <= id_ctrl;
               ex_is_load_r    <= id_is_load;
               ex_is_multi_r   <= id_is_multi;
            end else begin
               ex_valid_r      <= 1'b0;
               ex_rA_address_r <= 5'd0;
               ex_rB_address_r <= 5'd0;
               ex_rD_address_r <= 5'd0;
               ex_rA_data_r    <= {DATA_WIDTH{1'b0}};
               ex_rB_data_r    <= {DATA_WIDTH{1'b0}};
               ex_ctrl_r       <= {CTRL_WIDTH{1'b0}};
               ex_is_load_r    <= 1'b0;
               ex_is_multi_r   <= 1'b0;
            end
         end
      end
   end

`ifdef ID_EX_PERF_CNT_EN
   logic [31:0] stall_cycles_r;
   logic [31:0] bubble_count_r;

   // Free-running event counters, wrapping modulo 2^32.
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cycles_r <= 32'd0;
         bubble_count_r <= 32'd0;
      end else begin
         stall_cycles_r <= stall_cycles_r + {31'd0, stall_s};
         bubble_count_r <= bubble_count_r + {31'd0, bubble_evt_s};
      end
   end

   assign stall_cycles = stall_cycles_r;
   assign bubble_count = bubble_count_r;
`endif

   assign stall_id      = stall_s;
   assign ex_busy       = busy_r;
   assign ex_valid      = ex_valid_r;
   assign ex_rA_address = ex_rA_address_r;
   assign ex_rB_address = ex_rB_address_r;
   assign ex_rD_address = ex_rD_address_r;
   assign ex_rA_data    = ex_rA_data_r;
   assign ex_rB_data    = ex_rB_data_r;
   assign ex_ctrl       = ex_ctrl_r;
   assign ex_is_load    = ex_is_load_r;
   assign ex_is_multi   = ex_is_multi_r;

endmodule
